sha256_core_mb: RTL and testbench
=================================

# sha256_core_mb

Parametrised, multi-block successor of the byte-addressed SHA-256 compression core. The host loads one 512-bit message block through the 8-bit register port and starts it. The core then runs the 64 rounds at a configurable number of rounds per clock and folds the result into a persistent digest register. Blocks can be chained, so messages longer than one block hash without host-side arithmetic. The block sits on the same 7-bit-address peripheral bus as its predecessor and uses the same register map, with an extended status register.

## Interface
- ROUNDS_PER_CYCLE, 1, combinational rounds unrolled per clock; legal values 1, 2, 4, 8, 16; any other value is a elaboration error.
- REVISION_DATA, 8'd52, value returned at address 66.
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_w_addr  in  7  register address, for reads and writes.
- i_data8  in  8  write data.
- i_we  in  1  write strobe; one byte written per cycle.
- o_irq  out  1  level copy of the sticky DONE bit; 0 after reset.
- o_data_mux  out  8  combinational read data for i_w_addr; 0x00 at reset for address 0.

## Operation
- **Register map:**
  - 0–63: message bytes, write-only; read 0x00. Address a maps to bits [8a+7:8a] of the 512-bit word vector. W0 is bits 511:480 and address 63 is the MSB byte of W0; W15 is bits 31:0.
  - 64: WHO_AM_I, reads 0x07.
  - 65: STATUS.
  - 66: REVISION_DATA.
  - 67, 68, 69: reads 0x13, 0x03, 0x13.
  - 70–101: digest, read-only. Address 70+k returns bits [8k+7:8k] of H = {H0..H7}, so address 101 is the MSB of H0.
  - 102–127: read 0xAA.
- **STATUS read:** {state[1:0], WR_ERR, CONT, DONE, RUNNING, READY, 1'b0}.
  - READY = (state==IDLE).
  - RUNNING = (state==ROUND or ADD).
- **STATUS write, idle only:**
  - bit0=1 starts a block.
  - bit4 is written into CONT.
  - bit3=1 clears DONE.
  - bit5=1 clears WR_ERR.
- **FSM states:** IDLE=0, ROUND=1, ADD=2 (3 unused, decodes to IDLE).
  - IDLE→ROUND: on a STATUS write with bit0=1. On that edge:
    - Working vars a..h ← (new CONT ? H : HASH_INIT).
    - If new CONT=0, H ← HASH_INIT.
    - Round counter ← 0.
    - DONE ← 0.
  - ROUND: each cycle applies ROUNDS_PER_CYCLE rounds with K[cnt..cnt+R-1] and advances the message schedule by R words. Counter += R.
  - ROUND→ADD: on the cycle where cnt == 64−R.
  - ADD→IDLE: H[i] ← H[i] + var[i] mod 2^32 for each of the 8 words; DONE ← 1.
- **Arithmetic:** all additions are 32-bit, wrap mod 2^32. The round counter is 7 bits and never exceeds 64.
- **Message area after a block:** it holds the schedule residue (W48..W63). The host must rewrite all 64 bytes before the next block.
- **Writes while RUNNING:** any write, to any address including STATUS, is discarded and sets WR_ERR. It does not affect words, state or H.
- **Writes in IDLE to read-only addresses (64, 66–127):** ignored, no error.
- **Start write in the same cycle as DONE=1:** the start wins and DONE clears. If bit3 is also 1, the result is the same.
- **Reset:** i_rst=1 at any edge, including mid-ROUND, forces:
  - state=IDLE, counter=0, words=0;
  - H=vars=HASH_INIT;
  - CONT=DONE=WR_ERR=0.
  - STATUS then reads 0x02 and o_irq=0 from the following cycle.

## Timing
- Start write in cycle T. ROUND occupies cycles T+1 … T+64/R. ADD occupies cycle T+64/R+1.
- DONE, o_irq and the new digest are visible from cycle T+64/R+2.
  - R=1: 66 cycles.
  - R=16: 6 cycles.
- o_data_mux is purely combinational from i_w_addr and registers; zero-latency reads.
- Digest reads during ROUND/ADD return the previous H. H changes only on the ADD edge or the start edge with CONT=0.
- Back-to-back: a new start is accepted in the first IDLE cycle, i.e. T+64/R+2.

## Test plan
- **Reset defaults:** assert i_rst 2 cycles → STATUS=0x02, o_irq=0, addr 101=0x6a, addr 70=0x19, addr 64=0x07, addr 120=0xAA.
- **Single block "abc", R=1:**
  - Stimulus: write W0=0x61626380 (addr 63..60 = 61,62,63,80), W15=0x00000018 (addr 0=0x18), rest 0; STATUS ← 0x01.
  - Response: o_irq rises exactly 66 cycles after the write; digest ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad (addr 101=0xba, addr 70=0xad); STATUS=0x0A.
- **Two-block chain, "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", R=4:**
  - Stimulus: block 1 with STATUS ← 0x01; after o_irq, rewrite the message area with block 2 and STATUS ← 0x11.
  - Response: digest 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1; each block signals o_irq 18 cycles after its start write.
- **Parameter sweep:** repeat "abc" for R ∈ {1, 2, 4, 8, 16} → identical digest; latency 64/R+2.
- **Busy-write protection:** during ROUND, write addr 63 ← 0xFF and STATUS ← 0x01 → digest still correct, WR_ERR=1 (STATUS bit5) after completion. Writing STATUS ← 0x28 clears both DONE and WR_ERR (STATUS=0x02).
- **Reset mid-operation:** start "abc", assert i_rst at cycle T+30 for 1 cycle → next cycle STATUS=0x02, o_irq=0, digest = HASH_INIT. A subsequent reload and start yields the correct "abc" digest.

Source files
------------

// File: rtl/sha256_core_mb_if.sv
// 8-bit peripheral register bus of the multi-block SHA-256 core.
// The host drives address, write data and strobe; the core returns combinational read data and its IRQ level.
interface sha256_core_mb_if;
  logic [6:0] i_w_addr;
  logic [7:0] i_data8;
  logic       i_we;
  logic       o_irq;
  logic [7:0] o_data_mux;

  modport master (output i_w_addr, i_data8, i_we, input o_irq, o_data_mux);
  modport slave  (input i_w_addr, i_data8, i_we, output o_irq, o_data_mux);
endinterface

// File: rtl/sha256_core_mb.sv
// Multi-block SHA-256 compression core: a block completes 64/ROUNDS_PER_CYCLE+2 cycles after its start write.
// Reads are zero-latency; bus writes during ROUND/ADD are dropped and latched into WR_ERR.
module sha256_core_mb #(
  parameter int         ROUNDS_PER_CYCLE = 1,
  parameter logic [7:0] REVISION_DATA    = 8'd52
) (
  input logic             i_clk,
  input logic             i_rst,
  sha256_core_mb_if.slave bus
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUND = 2'd1;
  localparam logic [1:0] ST_ADD   = 2'd2;
  localparam logic [6:0] LAST_CNT = 7'(64 - ROUNDS_PER_CYCLE);
  localparam logic [255:0] HASH_INIT =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
        ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16)) begin : g_bad_rpc
    $error("ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  logic [1:0]   state_q, state_d;
  logic [6:0]   cnt_q, cnt_d;
  logic [511:0] msg_q, msg_d;
  logic [255:0] h_q, h_d, v_q, v_d;
  logic         cont_q, cont_d, done_q, done_d, wr_err_q, wr_err_d;

  logic         running;
  logic [255:0] v_rnd;
  logic [511:0] sch_rnd;
  logic [31:0]  va, vb, vc, vd, ve, vf, vg, vh, t1, t2, wnew;
  logic [7:0]   status, rd_data;
  logic [4:0]   dig_idx;

  assign running = (state_q == ST_ROUND) || (state_q == ST_ADD);

  // Message area doubles as the 16-word schedule window: W[t] sits in the top word.
  always_comb begin
    {va, vb, vc, vd, ve, vf, vg, vh} = v_q;
    sch_rnd = msg_q;
    t1      = '0;
    t2      = '0;
    wnew    = '0;
    for (int r = 0; r < ROUNDS_PER_CYCLE; r++) begin
      t1   = vh + bsig1(ve) + ((ve & vf) ^ (~ve & vg)) + K[cnt_q[5:0] + 6'(r)] + sch_rnd[511:480];
      t2   = bsig0(va) + ((va & vb) ^ (va & vc) ^ (vb & vc));
      wnew = ssig1(sch_rnd[63:32]) + sch_rnd[223:192] + ssig0(sch_rnd[479:448]) + sch_rnd[511:480];
      vh = vg; vg = vf; vf = ve; ve = vd + t1;
      vd = vc; vc = vb; vb = va; va = t1 + t2;
      sch_rnd = {sch_rnd[479:0], wnew};
    end
    v_rnd = {va, vb, vc, vd, ve, vf, vg, vh};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    msg_d    = msg_q;
    h_d      = h_q;
    v_d      = v_q;
    cont_d   = cont_q;
    done_d   = done_q;
    wr_err_d = wr_err_q;
    if (bus.i_we && running) wr_err_d = 1'b1;
    case (state_q)
      ST_ROUND: begin
        v_d   = v_rnd;
        msg_d = sch_rnd;
        cnt_d = cnt_q + 7'(ROUNDS_PER_CYCLE);
        if (cnt_q == LAST_CNT) state_d = ST_ADD;
      end
      ST_ADD: begin
        for (int i = 0; i < 8; i++) h_d[255-32*i -: 32] = h_q[255-32*i -: 32] + v_q[255-32*i -: 32];
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        if (bus.i_we) begin
          if (bus.i_w_addr < 7'd64) begin
            msg_d[{bus.i_w_addr[5:0], 3'b000} +: 8] = bus.i_data8;
          end else if (bus.i_w_addr == 7'd65) begin
            cont_d = bus.i_data8[4];
            if (bus.i_data8[3]) done_d = 1'b0;
            if (bus.i_data8[5]) wr_err_d = 1'b0;
            if (bus.i_data8[0]) begin
              v_d = bus.i_data8[4] ? h_q : HASH_INIT;
              if (!bus.i_data8[4]) h_d = HASH_INIT;
              cnt_d   = '0;
              done_d  = 1'b0;
              state_d = ST_ROUND;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      msg_q    <= '0;
      h_q      <= HASH_INIT;
      v_q      <= HASH_INIT;
      cont_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      msg_q    <= msg_d;
      h_q      <= h_d;
      v_q      <= v_d;
      cont_q   <= cont_d;
      done_q   <= done_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign status  = {state_q, wr_err_q, cont_q, done_q, running, !running, 1'b0};
  assign dig_idx = 5'(bus.i_w_addr - 7'd70);

  always_comb begin
    rd_data = 8'hAA;
    if (bus.i_w_addr < 7'd64) begin
      rd_data = 8'h00;
    end else if (bus.i_w_addr < 7'd70) begin
      case (bus.i_w_addr)
        7'd64:   rd_data = 8'h07;
        7'd65:   rd_data = status;
        7'd66:   rd_data = REVISION_DATA;
        7'd68:   rd_data = 8'h03;
        default: rd_data = 8'h13;
      endcase
    end else if (bus.i_w_addr < 7'd102) begin
      rd_data = h_q[{dig_idx, 3'b000} +: 8];
    end
  end

  assign bus.o_data_mux = rd_data;
  assign bus.o_irq      = done_q;
endmodule

// File: tb/tb_sha256_core_mb.sv
// Directed bench for sha256_core_mb: five instances (R=1..16) share the bus, writes gated per instance.
module tb_sha256_core_mb;
  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] w_addr;
  logic [7:0] wdata;
  logic       we;
  logic [4:0] sel;
  logic [7:0] mux [5];
  logic [4:0] irq_v;
  int         cur;
  int         errors = 0;
  int         checks = 0;

  localparam logic [255:0] INIT_DIG  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_DIG   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] CHAIN_DIG = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] CH_BLK1   = {"abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", 8'h80, 56'h0};
  localparam logic [511:0] CH_BLK2   = 512'h1c0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    sha256_core_mb_if bus ();
    assign bus.i_w_addr = w_addr;
    assign bus.i_data8  = wdata;
    assign bus.i_we     = we & sel[g];
    assign mux[g]       = bus.o_data_mux;
    assign irq_v[g]     = bus.o_irq;
    sha256_core_mb #(.ROUNDS_PER_CYCLE(1 << g), .REVISION_DATA(8'd52)) u_dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
    );
  end

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    w_addr = a; wdata = d; we = 1'b1;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic rd(input logic [6:0] a, output logic [7:0] d);
    @(negedge clk);
    w_addr = a;
    #1 d = mux[cur];
  endtask

  task automatic rd_digest(output logic [255:0] h);
    logic [7:0] b;
    for (int k = 0; k < 32; k++) begin
      rd(7'(70 + k), b);
      h[8*k +: 8] = b;
    end
  endtask

  task automatic load(input logic [511:0] blk);
    for (int a = 0; a < 64; a++) wr(7'(a), blk[8*a +: 8]);
  endtask

  // Called right after the start write returns; n counts cycles since the start write's cycle.
  task automatic wait_irq(output int n);
    n = 1;
    while (irq_v[cur] !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    logic [7:0] b;
    do_reset();
    cur = 0;
    rd(7'd65, b); checks++;
    if (b !== 8'h02) begin errors++; $display("FAIL reset_status got=%h exp=02", b); end
    checks++;
    if (irq_v !== 5'b0) begin errors++; $display("FAIL reset_irq got=%b exp=00000", irq_v); end
    rd(7'd101, b); checks++;
    if (b !== 8'h6a) begin errors++; $display("FAIL reset_h0_msb got=%h exp=6a", b); end
    rd(7'd70, b); checks++;
    if (b !== 8'h19) begin errors++; $display("FAIL reset_h7_lsb got=%h exp=19", b); end
    rd(7'd64, b); checks++;
    if (b !== 8'h07) begin errors++; $display("FAIL who_am_i got=%h exp=07", b); end
    rd(7'd120, b); checks++;
    if (b !== 8'hAA) begin errors++; $display("FAIL addr120 got=%h exp=aa", b); end
    rd(7'd66, b); checks++;
    if (b !== 8'd52) begin errors++; $display("FAIL revision got=%h exp=34", b); end
    rd(7'd68, b); checks++;
    if (b !== 8'h03) begin errors++; $display("FAIL addr68 got=%h exp=03", b); end
  endtask

  task automatic test_single_abc();
    logic [7:0]   b;
    logic [255:0] h;
    int           n;
    do_reset();
    sel = 5'b00001; cur = 0;
    load(ABC_BLK);
    wr(7'd65, 8'h01);
    w_addr = 7'd65; #1; checks++;
    if (mux[cur] !== 8'h44) begin errors++; $display("FAIL abc_status_round got=%h exp=44", mux[cur]); end
    wait_irq(n); checks++;
    if (n !== 66) begin errors++; $display("FAIL abc_latency got=%0d exp=66", n); end
    rd(7'd65, b); checks++;
    if (b !== 8'h0A) begin errors++; $display("FAIL abc_status_done got=%h exp=0a", b); end
    rd(7'd101, b); checks++;
    if (b !== 8'hba) begin errors++; $display("FAIL abc_msb got=%h exp=ba", b); end
    rd(7'd70, b); checks++;
    if (b !== 8'had) begin errors++; $display("FAIL abc_lsb got=%h exp=ad", b); end
    rd(7'd63, b); checks++;
    if (b !== 8'h00) begin errors++; $display("FAIL msg_read got=%h exp=00", b); end
    rd_digest(h); checks++;
    if (h !== ABC_DIG) begin errors++; $display("FAIL abc_digest got=%h exp=%h", h, ABC_DIG); end
  endtask

  task automatic test_chain();
    logic [7:0]   b;
    logic [255:0] h;
    int           n;
    do_reset();
    sel = 5'b00100; cur = 2;
    load(CH_BLK1);
    wr(7'd65, 8'h01);
    wait_irq(n); checks++;
    if (n !== 18) begin errors++; $display("FAIL chain_lat1 got=%0d exp=18", n); end
    load(CH_BLK2);
    wr(7'd65, 8'h11);
    w_addr = 7'd65; #1; checks++;
    if (mux[cur] !== 8'h54) begin errors++; $display("FAIL chain_status_round got=%h exp=54", mux[cur]); end
    wait_irq(n); checks++;
    if (n !== 18) begin errors++; $display("FAIL chain_lat2 got=%0d exp=18", n); end
    rd(7'd65, b); checks++;
    if (b !== 8'h1A) begin errors++; $display("FAIL chain_status_done got=%h exp=1a", b); end
    rd_digest(h); checks++;
    if (h !== CHAIN_DIG) begin errors++; $display("FAIL chain_digest got=%h exp=%h", h, CHAIN_DIG); end
  endtask

  task automatic test_sweep();
    logic [255:0] h;
    int           n;
    for (int g = 0; g < 5; g++) begin
      do_reset();
      sel = 5'(1 << g); cur = g;
      load(ABC_BLK);
      wr(7'd65, 8'h01);
      wait_irq(n); checks++;
      if (n !== (64 >> g) + 2) begin errors++; $display("FAIL sweep_lat r=%0d got=%0d exp=%0d", 1 << g, n, (64 >> g) + 2); end
      rd_digest(h); checks++;
      if (h !== ABC_DIG) begin errors++; $display("FAIL sweep_digest r=%0d got=%h exp=%h", 1 << g, h, ABC_DIG); end
    end
  endtask

  task automatic test_busy_write();
    logic [7:0]   b;
    logic [255:0] h;
    int           n;
    do_reset();
    sel = 5'b00001; cur = 0;
    load(ABC_BLK);
    wr(7'd65, 8'h01);
    wr(7'd63, 8'hFF);
    wr(7'd65, 8'h01);
    wait_irq(n); checks++;
    if (n >= 300) begin errors++; $display("FAIL busy_timeout got=%0d exp<300", n); end
    rd_digest(h); checks++;
    if (h !== ABC_DIG) begin errors++; $display("FAIL busy_digest got=%h exp=%h", h, ABC_DIG); end
    rd(7'd65, b); checks++;
    if (b !== 8'h2A) begin errors++; $display("FAIL busy_status got=%h exp=2a", b); end
    wr(7'd65, 8'h28);
    rd(7'd65, b); checks++;
    if (b !== 8'h02) begin errors++; $display("FAIL busy_clear got=%h exp=02", b); end
    checks++;
    if (irq_v[cur] !== 1'b0) begin errors++; $display("FAIL busy_clear_irq got=%b exp=0", irq_v[cur]); end
  endtask

  task automatic test_reset_mid();
    logic [255:0] h;
    int           n;
    do_reset();
    sel = 5'b00001; cur = 0;
    load(ABC_BLK);
    wr(7'd65, 8'h01);
    repeat (29) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    w_addr = 7'd65; #1; checks++;
    if (mux[cur] !== 8'h02) begin errors++; $display("FAIL midrst_status got=%h exp=02", mux[cur]); end
    checks++;
    if (irq_v[cur] !== 1'b0) begin errors++; $display("FAIL midrst_irq got=%b exp=0", irq_v[cur]); end
    rd_digest(h); checks++;
    if (h !== INIT_DIG) begin errors++; $display("FAIL midrst_digest got=%h exp=%h", h, INIT_DIG); end
    load(ABC_BLK);
    wr(7'd65, 8'h01);
    wait_irq(n); checks++;
    if (n !== 66) begin errors++; $display("FAIL midrst_lat got=%0d exp=66", n); end
    rd_digest(h); checks++;
    if (h !== ABC_DIG) begin errors++; $display("FAIL midrst_redo got=%h exp=%h", h, ABC_DIG); end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; w_addr = '0; wdata = '0; sel = 5'b00001; cur = 0;
    test_reset();
    test_single_abc();
    test_chain();
    test_sweep();
    test_busy_write();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
